// File: rtl/window_scheduler.sv
// window_scheduler: slices a base stream into overlapping windows and sequences one
// window_hasher per window (reset, start, wait for done), then offers the captured
// sketch downstream over a valid/ready handshake.
module window_scheduler #(
    parameter int unsigned SKETCH_SIZE    = 16,
    parameter int unsigned NUM_OF_BUCKETS = 256,
    parameter int unsigned WINDOW_SIZE    = 128,
    parameter int unsigned STRIDE         = 64,
    parameter int unsigned INDEX_WIDTH    = 16,
    localparam int unsigned EntryW        = $clog2(NUM_OF_BUCKETS)
) (
    input  logic                                 clk,
    input  logic                                 reset_window_scheduler,
    input  logic [1:0]                           base_in,
    input  logic                                 base_valid,
    input  logic                                 base_last,
    output logic                                 base_ready,
    output logic [WINDOW_SIZE-1:0][1:0]          window,
    output logic                                 reset_window_hasher,
    output logic                                 ready_for_hashing,
    input  logic [SKETCH_SIZE-1:0][EntryW-1:0]   hashed_sketch,
    input  logic                                 hashing_is_done,
    output logic [SKETCH_SIZE-1:0][EntryW-1:0]   sketch_out,
    output logic                                 sketch_valid,
    input  logic                                 sketch_ready,
    output logic                                 sketch_last,
    output logic [INDEX_WIDTH-1:0]               window_index,
    output logic                                 tail_dropped
);

    localparam int unsigned CntW = $clog2(WINDOW_SIZE + 1);

    localparam logic [CntW-1:0]        WinCnt    = CntW'(WINDOW_SIZE);
    localparam logic [CntW-1:0]        StrideCnt = CntW'(STRIDE);
    localparam logic [CntW-1:0]        CntOne    = CntW'(1);
    localparam logic [INDEX_WIDTH-1:0] IdxOne    = INDEX_WIDTH'(1);

    localparam logic [2:0] StFill     = 3'd0;
    localparam logic [2:0] StHashRst  = 3'd1;
    localparam logic [2:0] StHashGo   = 3'd2;
    localparam logic [2:0] StHashWait = 3'd3;
    localparam logic [2:0] StEmit     = 3'd4;

    logic [2:0]                         state_q, state_d;
    logic [CntW-1:0]                    fill_cnt_q, fill_cnt_d;
    logic                               have_window_q, have_window_d;
    logic                               last_pending_q, last_pending_d;
    logic [INDEX_WIDTH-1:0]             window_index_q, window_index_d;
    logic [WINDOW_SIZE-1:0][1:0]        window_q, window_d;
    logic [SKETCH_SIZE-1:0][EntryW-1:0] sketch_q, sketch_d;
    logic                               tail_dropped_q, tail_dropped_d;

    logic [CntW-1:0] fill_next;
    logic            trigger;

    // Count includes the base being accepted; first window needs a full load,
    // later ones only STRIDE fresh bases.
    assign fill_next = fill_cnt_q + CntOne;
    assign trigger   = have_window_q ? (fill_next == StrideCnt) : (fill_next == WinCnt);

    // Next-state logic for the sequencing FSM and its datapath registers
    always_comb begin
        state_d        = state_q;
        fill_cnt_d     = fill_cnt_q;
        have_window_d  = have_window_q;
        last_pending_d = last_pending_q;
        window_index_d = window_index_q;
        window_d       = window_q;
        sketch_d       = sketch_q;
        tail_dropped_d = 1'b0;

        case (state_q)
            StFill: begin
                if (base_valid) begin
                    window_d = {base_in, window_q[WINDOW_SIZE-1:1]};
                    if (trigger) begin
                        fill_cnt_d     = '0;
                        have_window_d  = 1'b1;
                        last_pending_d = base_last;
                        state_d        = StHashRst;
                    end else if (base_last) begin
                        // Read ended mid-window: discard the partial and start afresh
                        tail_dropped_d = 1'b1;
                        fill_cnt_d     = '0;
                        have_window_d  = 1'b0;
                        window_index_d = '0;
                    end else begin
                        fill_cnt_d = fill_next;
                    end
                end
            end
            StHashRst: state_d = StHashGo;
            StHashGo:  state_d = StHashWait;
            StHashWait: begin
                if (hashing_is_done) begin
                    sketch_d = hashed_sketch;
                    state_d  = StEmit;
                end
            end
            StEmit: begin
                if (sketch_ready) begin
                    if (last_pending_q) begin
                        window_index_d = '0;
                        have_window_d  = 1'b0;
                        last_pending_d = 1'b0;
                    end else begin
                        window_index_d = window_index_q + IdxOne;
                    end
                    state_d = StFill;
                end
            end
            default: state_d = StFill;
        endcase
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge reset_window_scheduler) begin
        if (reset_window_scheduler) begin
            state_q        <= StFill;
            fill_cnt_q     <= '0;
            have_window_q  <= 1'b0;
            last_pending_q <= 1'b0;
            window_index_q <= '0;
            window_q       <= '0;
            sketch_q       <= '0;
            tail_dropped_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            fill_cnt_q     <= fill_cnt_d;
            have_window_q  <= have_window_d;
            last_pending_q <= last_pending_d;
            window_index_q <= window_index_d;
            window_q       <= window_d;
            sketch_q       <= sketch_d;
            tail_dropped_q <= tail_dropped_d;
        end
    end

    // Outputs decoded from state; hasher stays in reset while we are
    always_comb begin
        base_ready          = (state_q == StFill) && !reset_window_scheduler;
        reset_window_hasher = reset_window_scheduler || (state_q == StHashRst);
        ready_for_hashing   = (state_q == StHashGo);
        sketch_valid        = (state_q == StEmit);
        sketch_last         = (state_q == StEmit) && last_pending_q;
        sketch_out          = sketch_q;
        window              = window_q;
        window_index        = window_index_q;
        tail_dropped        = tail_dropped_q;
    end

endmodule

// File: tb/tb_window_scheduler.sv
// Bench for window_scheduler: W=8, S=4, two 8-bit sketch entries, behavioural hasher
// with a 10-cycle latency. A read-level model predicts windows, sketches and tail drops.
module tb_window_scheduler;

    localparam int W  = 8;
    localparam int S  = 4;
    localparam int SS = 2;
    localparam int NB = 256;
    localparam int IW = 16;
    localparam int EW = 8;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [1:0]                base_in;
    logic                      base_valid, base_last, base_ready;
    logic [W-1:0][1:0]         window;
    logic                      rwh, rfh;
    logic [SS-1:0][EW-1:0]     hashed_sketch, sketch_out;
    logic                      hashing_is_done, sketch_valid, sketch_ready, sketch_last;
    logic [IW-1:0]             window_index;
    logic                      tail_dropped;

    always #5 clk = ~clk;

    window_scheduler #(
        .SKETCH_SIZE(SS), .NUM_OF_BUCKETS(NB), .WINDOW_SIZE(W), .STRIDE(S), .INDEX_WIDTH(IW)
    ) dut (
        .clk                    (clk),
        .reset_window_scheduler (rst),
        .base_in                (base_in),
        .base_valid             (base_valid),
        .base_last              (base_last),
        .base_ready             (base_ready),
        .window                 (window),
        .reset_window_hasher    (rwh),
        .ready_for_hashing      (rfh),
        .hashed_sketch          (hashed_sketch),
        .hashing_is_done        (hashing_is_done),
        .sketch_out             (sketch_out),
        .sketch_valid           (sketch_valid),
        .sketch_ready           (sketch_ready),
        .sketch_last            (sketch_last),
        .window_index           (window_index),
        .tail_dropped           (tail_dropped)
    );

    // Behavioural hasher: done rises 10 cycles after the start strobe, cleared by reset
    logic        h_done = 1'b0;
    int          h_cnt = 0;
    logic [15:0] hash_sk;
    logic        force_done;

    always @(posedge clk) begin
        if (rwh) begin
            h_cnt  <= 0;
            h_done <= 1'b0;
        end else if (rfh) begin
            h_cnt <= 1;
        end else if (h_cnt != 0 && !h_done) begin
            if (h_cnt == 10) h_done <= 1'b1;
            else h_cnt <= h_cnt + 1;
        end
    end

    assign hashing_is_done = h_done | force_done;
    assign hashed_sketch   = h_done ? hash_sk : 16'h0;

    // Model state and DUT observation logs
    typedef struct {
        logic [15:0] sk;
        logic [15:0] idx;
        logic        last;
    } exp_t;

    exp_t        exp_sk[$];
    logic [15:0] exp_win[$];
    int          exp_tail = 0;
    logic [1:0]  rd[$];

    int          n_tests = 0;
    int          n_fail = 0;
    int          acc_count = 0;
    int          tail_cnt = 0;
    logic [15:0] acc_idx[$];
    logic        acc_last[$];
    logic [15:0] last_sk;
    logic [15:0] win_log[$];

    task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: window k covers bases k*S .. k*S+W-1; a read whose length is not
    // W + n*S ends with a dropped tail.
    task automatic model_read();
        int   len = rd.size();
        int   k = 0;
        bit   ended = 0;
        exp_t e;
        logic [15:0] wv;
        while (k * S + W <= len) begin
            wv = 16'h0;
            for (int j = 0; j < W; j++) wv[j*2 +: 2] = rd[k*S + j];
            exp_win.push_back(wv);
            e.sk   = hash_sk;
            e.idx  = 16'(k);
            e.last = (k * S + W == len);
            if (e.last) ended = 1;
            exp_sk.push_back(e);
            k++;
        end
        if (!ended) exp_tail++;
    endtask

    // Called at posedge+1; returns at posedge+1 after the base was accepted
    task automatic send_base(input logic [1:0] b, input logic last);
        int t = 0;
        base_in    = b;
        base_last  = last;
        base_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (base_ready) break;
            t++;
            if (t >= 500) break;
        end
        check_eq("base_accept_timeout", t < 500, 1);
        @(posedge clk);
        #1;
        base_valid = 1'b0;
        base_last  = 1'b0;
    endtask

    task automatic send_read();
        model_read();
        for (int i = 0; i < rd.size(); i++) send_base(rd[i], i == rd.size() - 1);
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((exp_sk.size() != 0 || exp_tail != 0) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check_eq("idle_timeout", t < 2000, 1);
        @(posedge clk);
        #1;
    endtask

    // Per-cycle compare against the model and the handshake/pulse rules
    initial begin : compare
        logic        p_rwh, p_rfh, p_stall, p_tail, p_last;
        logic [15:0] p_sk, p_idx;
        exp_t        e;
        logic [15:0] wv;
        p_rwh = 0; p_rfh = 0; p_stall = 0; p_tail = 0; p_last = 0; p_sk = 0; p_idx = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                p_rwh = 0; p_rfh = 0; p_stall = 0; p_tail = 0;
            end else begin
                if (rwh) check_eq("hasher_rst_pulse_len", p_rwh, 0);
                if (p_rwh) check_eq("go_follows_hasher_rst", rfh, 1);
                if (rfh) begin
                    check_eq("go_pulse_len", p_rfh, 0);
                    check_eq("go_after_hasher_rst", p_rwh, 1);
                    check_eq("job_expected", exp_win.size() != 0, 1);
                    win_log.push_back(window);
                    if (exp_win.size() != 0) begin
                        wv = exp_win.pop_front();
                        check_eq("window_contents", window, wv);
                    end
                end
                if (sketch_valid) check_eq("base_ready_low_in_emit", base_ready, 0);
                if (p_stall) begin
                    check_eq("stall_valid", sketch_valid, 1);
                    check_eq("stall_sketch", sketch_out, p_sk);
                    check_eq("stall_index", window_index, p_idx);
                    check_eq("stall_last", sketch_last, p_last);
                end
                if (sketch_valid && sketch_ready) begin
                    check_eq("sketch_expected", exp_sk.size() != 0, 1);
                    acc_count++;
                    acc_idx.push_back(window_index);
                    acc_last.push_back(sketch_last);
                    last_sk = sketch_out;
                    if (exp_sk.size() != 0) begin
                        e = exp_sk.pop_front();
                        check_eq("sketch_out", sketch_out, e.sk);
                        check_eq("window_index", window_index, e.idx);
                        check_eq("sketch_last", sketch_last, e.last);
                    end
                end
                if (tail_dropped) begin
                    tail_cnt++;
                    check_eq("tail_expected", exp_tail > 0, 1);
                    check_eq("tail_pulse_len", p_tail, 0);
                    if (exp_tail > 0) exp_tail--;
                end
                p_rwh   = rwh;
                p_rfh   = rfh;
                p_stall = sketch_valid && !sketch_ready;
                p_sk    = sketch_out;
                p_idx   = window_index;
                p_last  = sketch_last;
                p_tail  = tail_dropped;
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int a0, t0, n0, t;
        rst = 1'b1; base_in = 2'd0; base_valid = 1'b0; base_last = 1'b0;
        sketch_ready = 1'b1; force_done = 1'b0; hash_sk = 16'h0703;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_base_ready", base_ready, 0);
        check_eq("rst_hasher_rst", rwh, 1);
        check_eq("rst_go", rfh, 0);
        check_eq("rst_sketch_valid", sketch_valid, 0);
        check_eq("rst_sketch_last", sketch_last, 0);
        check_eq("rst_window", window, 0);
        check_eq("rst_sketch_out", sketch_out, 0);
        check_eq("rst_index", window_index, 0);
        check_eq("rst_tail", tail_dropped, 0);
        rst = 1'b0;
        #1;
        check_eq("release_base_ready", base_ready, 1);
        check_eq("release_hasher_rst", rwh, 0);
        @(posedge clk);
        #1;

        // 8-base read: exactly one final sketch {3,7}
        rd = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd3, 2'd2, 2'd1, 2'd0};
        a0 = acc_count;
        send_read();
        wait_idle();
        check_eq("t1_count", acc_count - a0, 1);
        check_eq("t1_index", acc_idx[acc_idx.size()-1], 0);
        check_eq("t1_last", acc_last[acc_last.size()-1], 1);
        check_eq("t1_sketch", last_sk, 16'h0703);

        // 16-base read: windows at bases 0..7, 4..11, 8..15
        hash_sk = 16'h1122;
        rd = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0,
               2'd1, 2'd2, 2'd3, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2};
        a0 = acc_count;
        n0 = win_log.size();
        send_read();
        wait_idle();
        check_eq("t2_count", acc_count - a0, 3);
        check_eq("t2_idx0", acc_idx[a0], 0);
        check_eq("t2_idx1", acc_idx[a0+1], 1);
        check_eq("t2_idx2", acc_idx[a0+2], 2);
        check_eq("t2_last_pattern", {acc_last[a0], acc_last[a0+1], acc_last[a0+2]}, 3'b001);
        check_eq("t2_second_window", win_log[n0+1], 16'h7939);

        // 10-base read: one non-final sketch, then a dropped tail
        hash_sk = 16'h0F05;
        rd = '{2'd3, 2'd3, 2'd2, 2'd1, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd2};
        a0 = acc_count;
        t0 = tail_cnt;
        send_read();
        wait_idle();
        check_eq("t3_count", acc_count - a0, 1);
        check_eq("t3_last", acc_last[a0], 0);
        check_eq("t3_tail", tail_cnt - t0, 1);
        rd = '{2'd2, 2'd0, 2'd1, 2'd3, 2'd2, 2'd0, 2'd1, 2'd3};
        a0 = acc_count;
        send_read();
        wait_idle();
        check_eq("t3_restart_count", acc_count - a0, 1);
        check_eq("t3_restart_index", acc_idx[a0], 0);

        // Downstream stall for 20 cycles in EMIT
        hash_sk = 16'h3344;
        sketch_ready = 1'b0;
        rd = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0, 2'd0};
        a0 = acc_count;
        send_read();
        t = 0;
        while (!sketch_valid && t < 200) begin
            @(negedge clk);
            t++;
        end
        check_eq("t4_valid_timeout", t < 200, 1);
        repeat (20) @(negedge clk);
        check_eq("t4_no_accept_while_stalled", acc_count - a0, 0);
        @(posedge clk);
        #1;
        sketch_ready = 1'b1;
        @(posedge clk);
        #1;
        check_eq("t4_accept_first_ready", acc_count - a0, 1);
        check_eq("t4_valid_dropped", sketch_valid, 0);
        wait_idle();

        // Reset during HASH_WAIT aborts the job
        hash_sk = 16'h7788;
        rd = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd2, 2'd3, 2'd2, 2'd3};
        a0 = acc_count;
        send_read();
        t = 0;
        while (!rfh && t < 50) begin
            @(negedge clk);
            t++;
        end
        check_eq("t5_go_timeout", t < 50, 1);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_eq("t5_rst_valid", sketch_valid, 0);
        check_eq("t5_rst_hasher_rst", rwh, 1);
        check_eq("t5_rst_base_ready", base_ready, 0);
        check_eq("t5_rst_go", rfh, 0);
        check_eq("t5_rst_window", window, 0);
        check_eq("t5_rst_sketch", sketch_out, 0);
        check_eq("t5_rst_index", window_index, 0);
        exp_sk.delete();
        exp_win.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_eq("t5_release_base_ready", base_ready, 1);
        check_eq("t5_no_sketch", acc_count - a0, 0);
        @(posedge clk);
        #1;
        hash_sk = 16'h5566;
        rd = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3};
        send_read();
        wait_idle();
        check_eq("t5_fresh_count", acc_count - a0, 1);
        check_eq("t5_fresh_index", acc_idx[acc_idx.size()-1], 0);
        check_eq("t5_fresh_sketch", last_sk, 16'h5566);

        // Spurious done during FILL is ignored
        force_done = 1'b1;
        rd = '{2'd1, 2'd0, 2'd3, 2'd2, 2'd1};
        a0 = acc_count;
        t0 = tail_cnt;
        send_read();
        wait_idle();
        repeat (10) @(posedge clk);
        #1;
        force_done = 1'b0;
        check_eq("t6_no_sketch", acc_count - a0, 0);
        check_eq("t6_valid_low", sketch_valid, 0);
        check_eq("t6_tail", tail_cnt - t0, 1);

        check_eq("final_windows_consumed", exp_win.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/window_scheduler.md
# window_scheduler

Sequencing controller that turns a per-base nucleotide stream into overlapping windows and drives one `window_hasher` instance through repeated hash jobs. Bases are shifted into a window register. Each time a full window (first window) or a further STRIDE bases (later windows) has accumulated, the block resets the hasher, starts it, waits for `hashing_is_done`, and presents the captured sketch downstream with a valid/ready handshake. It sits between the read-loading front end and the sketch consumer (bucket/table logic).

## Interface
- `SKETCH_SIZE`, 16: entries per sketch; must match the hasher.
- `NUM_OF_BUCKETS`, 256: h2 range; sketch entry width is `$clog2(NUM_OF_BUCKETS)`.
- `WINDOW_SIZE`, 128: bases per window; must match the hasher.
- `STRIDE`, 64: new bases between consecutive windows of one read; legal range 1..WINDOW_SIZE.
- `INDEX_WIDTH`, 16: width of `window_index`.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset_window_scheduler`  in  1  asynchronous, active-high reset.
- `base_in`  in  2  nucleotide code.
- `base_valid`  in  1  `base_in` is valid.
- `base_last`  in  1  qualifies `base_in` as the last base of the current read.
- `base_ready`  out  1  scheduler accepts a base this cycle.
- `window`  out  2 x WINDOW_SIZE  window register; `[0]` is oldest and `[WINDOW_SIZE-1]` is newest; feeds the hasher.
- `reset_window_hasher`  out  1  reset to the hasher.
- `ready_for_hashing`  out  1  start strobe to the hasher.
- `hashed_sketch`  in  `$clog2(NUM_OF_BUCKETS)` x SKETCH_SIZE  sketch returned by the hasher.
- `hashing_is_done`  in  1  hasher done level; stays high until the hasher is reset.
- `sketch_out`  out  `$clog2(NUM_OF_BUCKETS)` x SKETCH_SIZE  captured sketch.
- `sketch_valid`  out  1  `sketch_out` is valid.
- `sketch_ready`  in  1  consumer accepts the sketch.
- `sketch_last`  out  1  the sketch is the final window of its read; qualified by `sketch_valid`.
- `window_index`  out  INDEX_WIDTH  ordinal of the window within its read, starting at 0; qualified by `sketch_valid`.
- `tail_dropped`  out  1  one-cycle pulse when a read ends with an incomplete window.

## Operation
- FSM states: FILL, HASH_RST, HASH_GO, HASH_WAIT, EMIT.
- **FILL**
  - `base_ready`=1.
  - On accept (`base_valid`&`base_ready`): shift `window` down by one and load `base_in` into `[WINDOW_SIZE-1]`.
  - `fill_cnt`++. `fill_cnt` is the count of bases since the last window trigger.
  - Window trigger: `fill_cnt` reaches WINDOW_SIZE when `have_window`=0, or reaches STRIDE when `have_window`=1, counting the current base.
  - On trigger: set `fill_cnt`=0 and `have_window`=1, latch `last_pending`=`base_last`, then go to HASH_RST.
  - Accepted `base_last` without a trigger: pulse `tail_dropped` next cycle; set `fill_cnt`=0, `have_window`=0, `window_index`=0; stay in FILL. `window` contents are don't-care.
- **HASH_RST**: `reset_window_hasher`=1 for exactly one cycle, then HASH_GO.
- **HASH_GO**: `ready_for_hashing`=1 for exactly one cycle, then HASH_WAIT.
- **HASH_WAIT**: when `hashing_is_done`=1, register `hashed_sketch` into `sketch_out` and go to EMIT.
- **EMIT**
  - `sketch_valid`=1; `sketch_last`=`last_pending`.
  - On `sketch_ready`: if `last_pending`, clear `window_index`, `have_window` and `last_pending`; otherwise `window_index`++, wrapping modulo 2^INDEX_WIDTH. Then go to FILL.
- `window` is held constant in every state except FILL. `base_ready`=0 outside FILL.
- `reset_window_hasher` = `reset_window_scheduler` | (state==HASH_RST). The hasher is held in reset while the scheduler is in reset.
- `hashing_is_done` is ignored outside HASH_WAIT.

## Timing
- Reset (async assert, sync release): state=FILL; `fill_cnt`=0; `have_window`=0; `last_pending`=0; `window_index`=0; `window` all 0; `sketch_out` all 0; `sketch_valid`=0; `sketch_last`=0; `ready_for_hashing`=0; `tail_dropped`=0; `reset_window_hasher`=1; `base_ready`=0 while reset is asserted and 1 in the first cycle after release.
- Reset mid-job, in any state: abort immediately; no sketch is emitted; the partial window is lost.
- Trigger base accepted at edge N: HASH_RST during cycle N+1, HASH_GO during N+2, HASH_WAIT from N+3.
- `hashing_is_done` sampled high at edge M: `sketch_valid` high from cycle M+1.
- Accept at edge P: `base_ready`=1 again in cycle P+1.
- Scheduler overhead is 4 cycles plus hasher latency plus downstream stall.
- `sketch_valid`, `sketch_out`, `sketch_last` and `window_index` are stable while `sketch_valid`=1 and `sketch_ready`=0.
- STRIDE=WINDOW_SIZE gives non-overlapping windows. STRIDE=1 triggers on every base after the first window.

## Test plan
- W=8, S=4, SKETCH_SIZE=2, behavioural hasher with fixed 10-cycle latency returning {3,7}; stream 8 bases, `base_last` on the 8th → one sketch {3,7}, `window_index`=0, `sketch_last`=1; `reset_window_hasher` and `ready_for_hashing` each high exactly one cycle, in consecutive cycles.
- Same config, 16-base read → 3 sketches with indices 0,1,2; only the third has `sketch_last`=1; the second window is bases 4..11 in order.
- Same config, 10-base read with `base_last` on base 10 → one sketch (`sketch_last`=0), then a `tail_dropped` pulse; the next read restarts at index 0 and needs 8 bases.
- Hold `sketch_ready`=0 for 20 cycles in EMIT → `base_ready`=0 and all outputs stable throughout; accept occurs on the first `sketch_ready`=1 cycle.
- Assert reset during HASH_WAIT → all outputs at reset values in the same cycle; `reset_window_hasher`=1; after release, a fresh 8-base read produces index 0.
- `hashing_is_done` forced high during FILL → ignored; no sketch emitted.
